// File: rtl/register_serializer.sv
// -----------------------------------------------------------------------------
// register_serializer
//   Parallel-in / serial-out converter. A WIDTH-bit word is accepted over a
//   valid/ready handshake and shifted out one bit per enabled clock, with
//   registered first/last markers so the mating deserializer can frame it.
//   A new word may be accepted on the last-bit cycle of the current one,
//   giving back-to-back frames with no idle gap.
//
// Parameters
//   WIDTH      word width in bits (>= 2)
//   LSB_FIRST  1: bit 0 leaves first; 0: bit WIDTH-1 leaves first
//
// Ports
//   clk        rising-edge clock
//   clear_n    synchronous active-low reset
//   enable     cycle enable; when low all state holds and no handshake completes
//   loadValid  dataIn holds a word to send
//   loadReady  block can accept a word this cycle (combinational)
//   dataIn     parallel word, captured on loadValid & loadReady
//   serOut     serial data bit (registered)
//   serValid   serOut carries a valid bit (registered)
//   serFirst   current bit is the first of its word (registered)
//   serLast    current bit is the last of its word (registered)
//   busy       a word is in flight
// -----------------------------------------------------------------------------
module register_serializer #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             enable,
    input  logic             loadValid,
    output logic             loadReady,
    input  logic [WIDTH-1:0] dataIn,
    output logic             serOut,
    output logic             serValid,
    output logic             serFirst,
    output logic             serLast,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state, stateNext;
    logic [WIDTH-1:0] shiftReg, shiftRegNext;
    logic [CNT_W-1:0] count, countNext;
    logic             serOutNext, serValidNext, serFirstNext, serLastNext;
    logic             atLast;
    logic             accept;

    // Bit of word w that goes on the wire when the bit counter reads k.
    function automatic logic bitAt(input logic [WIDTH-1:0] w,
                                   input logic [CNT_W-1:0] k);
        logic [WIDTH-1:0] rev;
        rev = {<<{w}};
        return LSB_FIRST ? w[k] : rev[k];
    endfunction

    assign atLast    = (state == SHIFT) && (count == LAST_IDX);
    assign loadReady = enable && clear_n && ((state == IDLE) || atLast);
    assign accept    = loadValid && loadReady;
    assign busy      = (state == SHIFT);

    always_comb begin
        stateNext    = state;
        shiftRegNext = shiftReg;
        countNext    = count;
        serOutNext   = serOut;
        serValidNext = serValid;
        serFirstNext = serFirst;
        serLastNext  = serLast;

        if (accept) begin
            // Fresh word: its first bit is presented right after this edge,
            // whether we came from IDLE or from the last bit of a prior word.
            stateNext    = SHIFT;
            shiftRegNext = dataIn;
            countNext    = '0;
            serOutNext   = bitAt(dataIn, '0);
            serValidNext = 1'b1;
            serFirstNext = 1'b1;
            serLastNext  = 1'b0;
        end else if (state == SHIFT && enable) begin
            if (atLast) begin
                stateNext    = IDLE;
                countNext    = '0;
                serOutNext   = 1'b0;
                serValidNext = 1'b0;
                serFirstNext = 1'b0;
                serLastNext  = 1'b0;
            end else begin
                countNext    = count + CNT_W'(1);
                serOutNext   = bitAt(shiftReg, count + CNT_W'(1));
                serFirstNext = 1'b0;
                serLastNext  = ((count + CNT_W'(1)) == LAST_IDX);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state    <= IDLE;
            shiftReg <= '0;
            count    <= '0;
            serOut   <= 1'b0;
            serValid <= 1'b0;
            serFirst <= 1'b0;
            serLast  <= 1'b0;
        end else begin
            state    <= stateNext;
            shiftReg <= shiftRegNext;
            count    <= countNext;
            serOut   <= serOutNext;
            serValid <= serValidNext;
            serFirst <= serFirstNext;
            serLast  <= serLastNext;
        end
    end

endmodule
